// File: rtl/pong_match_controller.sv
// Match sequencer for an N-player Pong game: scores, serve/rally/point/game-over flow.
// Optional PONG_WIN_BY_TWO_EN: a win also needs a 2-point lead over every other player.
module pong_match_controller #(
   parameter int unsigned NUM_PLAYERS           = 2,
   parameter int unsigned SCORE_WIDTH           = 4,
   parameter int unsigned POINTS_TO_WIN         = 11,
   parameter int unsigned SERVE_DELAY_IN_CLOCKS = 10000,
   parameter int unsigned POINT_HOLD_IN_CLOCKS  = 5000
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 start,
   input  logic [NUM_PLAYERS-1:0]               point_scored,
   output logic [NUM_PLAYERS*SCORE_WIDTH-1:0]   scores,
   output logic                                 ball_enable,
   output logic                                 ball_recentre,
   output logic [$clog2(NUM_PLAYERS)-1:0]       serve_player,
   output logic                                 game_over,
   output logic [$clog2(NUM_PLAYERS)-1:0]       winner,
   output logic [2:0]                           match_state
);

   localparam int unsigned PW      = $clog2(NUM_PLAYERS);
   localparam int unsigned CNT_MAX = (SERVE_DELAY_IN_CLOCKS > POINT_HOLD_IN_CLOCKS) ?
                                     SERVE_DELAY_IN_CLOCKS : POINT_HOLD_IN_CLOCKS;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);
   localparam int unsigned SMAX    = (1 << SCORE_WIDTH) - 1;

   localparam logic [CW-1:0] SERVE_LOAD = CW'(SERVE_DELAY_IN_CLOCKS - 1);
   localparam logic [CW-1:0] HOLD_LOAD  = CW'(POINT_HOLD_IN_CLOCKS - 1);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_SERVE_WAIT = 3'd1,
      S_RALLY      = 3'd2,
      S_POINT_HOLD = 3'd3,
      S_GAME_OVER  = 3'd4
   } state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [SCORE_WIDTH-1:0] score_q [NUM_PLAYERS];
   logic [SCORE_WIDTH-1:0] score_d [NUM_PLAYERS];
   logic [PW-1:0]          serve_q, serve_d;
   logic [PW-1:0]          winner_q, winner_d;
   logic                   armed_q, armed_d;
   logic                   recentre_q, recentre_d;
   logic                   ball_en_q;
   logic                   game_over_q;

   logic                   hit;
   logic [PW-1:0]          scorer;
   logic [SCORE_WIDTH-1:0] new_score;
   logic [PW-1:0]          serve_next;
   logic                   saturated;
   logic                   lead_ok;
   logic                   win;

   // Lowest-index scorer wins a simultaneous pulse; the rest are dropped.
   always_comb begin
      hit    = 1'b0;
      scorer = '0;
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
         if (point_scored[i] && !hit) begin
            hit    = 1'b1;
            scorer = PW'(i);
         end
      end
   end

   always_comb begin
      new_score  = (32'(score_q[scorer]) == SMAX) ? score_q[scorer]
                                                  : score_q[scorer] + SCORE_WIDTH'(1);
      saturated  = (32'(new_score) == SMAX);
      serve_next = (32'(scorer) == NUM_PLAYERS - 1) ? '0 : scorer + PW'(1);
      lead_ok    = 1'b1;
`ifdef PONG_WIN_BY_TWO_EN
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
         if (i != 32'(scorer) && 32'(new_score) < 32'(score_q[i]) + 32'd2) begin
            lead_ok = 1'b0;
         end
      end
`endif
      win = saturated || (32'(new_score) >= POINTS_TO_WIN && lead_ok);
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      score_d    = score_q;
      serve_d    = serve_q;
      winner_d   = winner_q;
      recentre_d = 1'b0;
      // A start level seen during a match never arms a restart; only a low level re-arms.
      if (!start) begin
         armed_d = 1'b1;
      end else if (state_q == S_IDLE || state_q == S_GAME_OVER) begin
         armed_d = armed_q;
      end else begin
         armed_d = 1'b0;
      end

      case (state_q)
         S_IDLE, S_GAME_OVER: begin
            if (start && armed_q) begin
               state_d    = S_SERVE_WAIT;
               cnt_d      = SERVE_LOAD;
               serve_d    = '0;
               recentre_d = 1'b1;
               armed_d    = 1'b0;
               for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
                  score_d[i] = '0;
               end
            end
         end
         S_SERVE_WAIT: begin
            if (cnt_q == '0) begin
               state_d = S_RALLY;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_RALLY: begin
            if (hit) begin
               score_d[scorer] = new_score;
               serve_d         = serve_next;
               if (win) begin
                  state_d  = S_GAME_OVER;
                  winner_d = scorer;
               end else begin
                  state_d = S_POINT_HOLD;
                  cnt_d   = HOLD_LOAD;
               end
            end
         end
         S_POINT_HOLD: begin
            if (cnt_q == '0) begin
               state_d    = S_SERVE_WAIT;
               cnt_d      = SERVE_LOAD;
               recentre_d = 1'b1;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         serve_q     <= '0;
         winner_q    <= '0;
         armed_q     <= 1'b1;
         recentre_q  <= 1'b0;
         ball_en_q   <= 1'b0;
         game_over_q <= 1'b0;
         for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
            score_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         serve_q     <= serve_d;
         winner_q    <= winner_d;
         armed_q     <= armed_d;
         recentre_q  <= recentre_d;
         ball_en_q   <= (state_d == S_RALLY);
         game_over_q <= (state_d == S_GAME_OVER);
         for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
            score_q[i] <= score_d[i];
         end
      end
   end

   always_comb begin
      scores = '0;
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
         scores[i*SCORE_WIDTH +: SCORE_WIDTH] = score_q[i];
      end
   end

   assign ball_enable   = ball_en_q;
   assign ball_recentre = recentre_q;
   assign serve_player  = serve_q;
   assign game_over     = game_over_q;
   assign winner        = winner_q;
   assign match_state   = state_q;

endmodule

// File: tb/tb_pong_match_controller.sv
// Directed bench for pong_match_controller: 2 players, first to 3, short serve/hold delays.
module tb_pong_match_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [1:0] point_scored;
   logic [7:0] scores;
   logic       ball_enable;
   logic       ball_recentre;
   logic       serve_player;
   logic       game_over;
   logic       winner;
   logic [2:0] match_state;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   pong_match_controller #(
      .NUM_PLAYERS           (2),
      .SCORE_WIDTH           (4),
      .POINTS_TO_WIN         (3),
      .SERVE_DELAY_IN_CLOCKS (4),
      .POINT_HOLD_IN_CLOCKS  (3)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .point_scored  (point_scored),
      .scores        (scores),
      .ball_enable   (ball_enable),
      .ball_recentre (ball_recentre),
      .serve_player  (serve_player),
      .game_over     (game_over),
      .winner        (winner),
      .match_state   (match_state)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_state(input string tag, input logic [2:0] target);
      for (int i = 0; i < 20 && match_state !== target; i++) tick();
      check(tag, 32'(match_state), 32'(target));
   endtask

   task automatic score_point(input logic [1:0] who);
      wait_state("reach_rally", 3'd2);
      point_scored = who;
      tick();
      point_scored = 2'b00;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; point_scored = 2'b00;
      tick(); tick();
      rst = 1'b0;
      check("rst_state",     32'(match_state),   32'd0);
      check("rst_scores",    32'(scores),        32'h00);
      check("rst_ball_en",   32'(ball_enable),   32'd0);
      check("rst_recentre",  32'(ball_recentre), 32'd0);
      check("rst_serve",     32'(serve_player),  32'd0);
      check("rst_game_over", 32'(game_over),     32'd0);
      check("rst_winner",    32'(winner),        32'd0);

      // start: exactly 4 cycles of SERVE_WAIT, recentre only in the first
      start = 1'b1;
      tick();
      check("sw_enter",    32'(match_state),   32'd1);
      check("sw_recentre", 32'(ball_recentre), 32'd1);
      check("sw_ball_en",  32'(ball_enable),   32'd0);
      tick();
      check("sw_c2",          32'(match_state),   32'd1);
      check("sw_recentre_lo", 32'(ball_recentre), 32'd0);
      tick();
      check("sw_c3", 32'(match_state), 32'd1);
      tick();
      check("sw_c4", 32'(match_state), 32'd1);
      tick();
      check("rally_enter",   32'(match_state), 32'd2);
      check("rally_ball_en", 32'(ball_enable), 32'd1);

      // player 1 scores
      point_scored = 2'b10;
      tick();
      point_scored = 2'b00;
      check("p1_state",   32'(match_state),  32'd3);
      check("p1_scores",  32'(scores),       32'h10);
      check("p1_serve",   32'(serve_player), 32'd0);
      check("p1_ball_en", 32'(ball_enable),  32'd0);
      tick();
      check("ph_c2", 32'(match_state), 32'd3);
      tick();
      check("ph_c3", 32'(match_state), 32'd3);
      tick();
      check("ph_exit",     32'(match_state),   32'd1);
      check("ph_recentre", 32'(ball_recentre), 32'd1);

      // pulse during SERVE_WAIT is ignored
      point_scored = 2'b01;
      tick();
      point_scored = 2'b00;
      check("sw_pulse_scores", 32'(scores), 32'h10);

      // simultaneous bits: player 0 only
      score_point(2'b11);
      check("both_scores", 32'(scores),       32'h11);
      check("both_serve",  32'(serve_player), 32'd1);
      score_point(2'b01);
      check("p0_scores", 32'(scores),       32'h12);
      check("p0_serve",  32'(serve_player), 32'd1);

      // reset mid-rally
      wait_state("pre_rst_rally", 3'd2);
      rst = 1'b1;
      start = 1'b0;
      tick();
      check("mrst_state",     32'(match_state),   32'd0);
      check("mrst_scores",    32'(scores),        32'h00);
      check("mrst_ball_en",   32'(ball_enable),   32'd0);
      check("mrst_recentre",  32'(ball_recentre), 32'd0);
      check("mrst_serve",     32'(serve_player),  32'd0);
      check("mrst_game_over", 32'(game_over),     32'd0);
      rst = 1'b0;
      tick();

      // player 1 wins 3-0; start held high throughout
      start = 1'b1;
      tick();
      check("m2_enter", 32'(match_state), 32'd1);
      score_point(2'b10);
      score_point(2'b10);
      score_point(2'b10);
      check("go_state",     32'(match_state), 32'd4);
      check("go_flag",      32'(game_over),   32'd1);
      check("go_winner",    32'(winner),      32'd1);
      check("go_scores",    32'(scores),      32'h30);
      check("go_ball_en",   32'(ball_enable), 32'd0);
      point_scored = 2'b01;
      tick();
      point_scored = 2'b00;
      tick();
      check("go_frozen",    32'(scores),      32'h30);
      check("go_no_rearm",  32'(match_state), 32'd4);

      // falling then rising start restarts the match
      start = 1'b0;
      tick();
      check("go_start_low", 32'(match_state), 32'd4);
      start = 1'b1;
      tick();
      check("restart_state",    32'(match_state),   32'd1);
      check("restart_scores",   32'(scores),        32'h00);
      check("restart_recentre", 32'(ball_recentre), 32'd1);
      check("restart_go_lo",    32'(game_over),     32'd0);

`ifdef PONG_WIN_BY_TWO_EN
      for (int i = 0; i < 6; i++) score_point((i % 2 == 0) ? 2'b01 : 2'b10);
      check("wb2_33_state",  32'(match_state), 32'd3);
      check("wb2_33_scores", 32'(scores),      32'h33);
      score_point(2'b01);
      check("wb2_43_state",  32'(match_state), 32'd3);
      check("wb2_43_scores", 32'(scores),      32'h34);
      score_point(2'b01);
      check("wb2_53_state",  32'(match_state), 32'd4);
      check("wb2_53_winner", 32'(winner),      32'd0);
      check("wb2_53_scores", 32'(scores),      32'h35);
`else
      for (int i = 0; i < 5; i++) score_point((i % 2 == 0) ? 2'b01 : 2'b10);
      check("ftw_state",  32'(match_state), 32'd4);
      check("ftw_winner", 32'(winner),      32'd0);
      check("ftw_scores", 32'(scores),      32'h23);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
